cmp_arbiter: RTL and testbench

CMP_ARBITER -- requirements
Module: cmp_arbiter

---
 rtl/cmp_arbiter_pkg.sv | 14 +
 rtl/cmp_arbiter_rr_picker.sv | 42 ++++
 rtl/cmp_arbiter.sv | 135 +++++++++++++
 tb/tb_cmp_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_arbiter_pkg.sv
// Shared types and default sizing for the cmp_arbiter block.
// Optional feature macro used by the block: CMP_ARBITER_EQ_EN (adds rsp_eq).
package cmp_arbiter_pkg;

    localparam int DEF_N    = 32;
    localparam int DEF_NREQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/cmp_arbiter_rr_picker.sv
// Round-robin picker: the first valid index found searching upward from ptr,
// wrapping NREQ-1 -> 0, returned as a one-hot grant and as a binary index.
module rr_picker #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // NOTE: every variable driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            // One extra bit keeps ptr+k from wrapping before the modulo fold.
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            cand = sum[IW-1:0];
            if (!any && valid[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbitrated signed less-than unit: IDLE accepts one request,
// CALC compares once, RESP holds the result until consumed. Macro: CMP_ARBITER_EQ_EN.
module cmp_arbiter
    import cmp_arbiter_pkg::*;
#(
    parameter  int N    = DEF_N,
    parameter  int NREQ = DEF_NREQ,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IW-1:0]   rsp_id,
    output logic            rsp_lt
`ifdef CMP_ARBITER_EQ_EN
    ,
    output logic            rsp_eq
`endif
);

    localparam logic [IW-1:0] LAST_ID = IW'(NREQ - 1);

    state_t          state, state_nxt;
    logic [IW-1:0]   rr;
    logic [IW-1:0]   id_q;
    logic [N-1:0]    a_q, b_q;
    logic [N-1:0]    a_sel, b_sel;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            take;

    rr_picker #(.NREQ(NREQ)) u_pick (
        .valid (req_valid),
        .ptr   (rr),
        .grant (grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Operand select is a one-hot AND-OR mux driven by the grant.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                a_sel = req_a[i*N +: N];
                b_sel = req_b[i*N +: N];
            end
        end
    end

    // rst_n gates req_ready so nothing is offered while reset is held.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = 1'b0;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && pick_any) begin
                    req_ready = grant;
                    take      = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Single shared comparator: signed a < b is the difference sign corrected
    // by overflow, which only occurs when the operand signs differ.
    logic [N-1:0] diff;
    logic         ovf;
    logic         lt_w;

    assign diff = a_q - b_q;
    assign ovf  = (a_q[N-1] ^ b_q[N-1]) & (diff[N-1] ^ a_q[N-1]);
    assign lt_w = diff[N-1] ^ ovf;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr     <= '0;
            id_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            rsp_id <= '0;
            rsp_lt <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                a_q  <= a_sel;
                b_q  <= b_sel;
                id_q <= pick_idx;
            end
            if (state == CALC) begin
                rsp_id <= id_q;
                rsp_lt <= lt_w;
            end
            if (state == RESP && rsp_ready) begin
                rr <= (id_q == LAST_ID) ? '0 : id_q + 1'b1;
            end
        end
    end

`ifdef CMP_ARBITER_EQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_eq <= 1'b0;
        end else if (state == CALC) begin
            rsp_eq <= (a_q == b_q);
        end
    end
`endif

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed and randomised self-checking bench for cmp_arbiter (NREQ=4, N=32).
module tb_cmp_arbiter;

    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int IW   = 2;
    localparam int NOPS = 10000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a = '0;
    logic [NREQ*N-1:0] req_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IW-1:0]     rsp_id;
    logic              rsp_lt;
`ifdef CMP_ARBITER_EQ_EN
    logic              rsp_eq;
`endif

    cmp_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_lt    (rsp_lt)
`ifdef CMP_ARBITER_EQ_EN
        ,
        .rsp_eq    (rsp_eq)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
    endtask

    // One complete transaction with rsp_ready held high.
    task automatic run_op(input logic [NREQ-1:0] mask, input int exp_id,
                          input logic exp_lt, input logic exp_eq, input string tag);
        req_valid = mask;
        #1;
        check({tag, "_grant"}, req_ready, 4'(1) << exp_id);
        tick;
        req_valid = '0;
        #1;
        check({tag, "_calc_valid"}, rsp_valid, 0);
        check({tag, "_calc_ready"}, req_ready, 0);
        tick;
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_id"}, rsp_id, exp_id);
        check({tag, "_lt"}, rsp_lt, exp_lt);
`ifdef CMP_ARBITER_EQ_EN
        check({tag, "_eq"}, rsp_eq, exp_eq);
`endif
        tick;
        check({tag, "_idle"}, rsp_valid, 0);
    endtask

    function automatic logic [N-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h0;
            3:       return 32'hFFFF_FFFF;
            4:       return N'($urandom_range(0, 15)) - 32'd8;
            default: return N'($urandom());
        endcase
    endfunction

    typedef struct {
        int   id;
        logic lt;
        logic eq;
    } exp_t;

    exp_t          sb[$];
    logic [N-1:0]  ra[NREQ];
    logic [N-1:0]  rb[NREQ];

    task automatic new_operands(input int i);
        ra[i] = rnd_val();
        rb[i] = ($urandom_range(0, 9) == 0) ? ra[i] : rnd_val();
        set_op(i, ra[i], rb[i]);
    endtask

    initial begin
        int          fair_ids[5];
        logic        fair_lt[4];
        int          last;
        int          w;
        int          issued;
        int          done;
        int          guard;
        logic [NREQ-1:0] acc;
        exp_t        e;

        // Reset: outputs and req_ready low while asserted, even with requests.
        req_valid = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_id", rsp_id, 0);
        check("rst_lt", rsp_lt, 0);
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        tick;

        // Basic and signed-overflow cases; rr advances 0 -> 1 -> 2 -> 3 -> 0.
        set_op(0, 32'd3, 32'd5);
        run_op(4'b0001, 0, 1'b1, 1'b0, "single");
        set_op(1, 32'h7FFF_FFFF, 32'h8000_0000);
        run_op(4'b0010, 1, 1'b0, 1'b0, "ovf_pos");
        set_op(2, 32'h8000_0000, 32'h7FFF_FFFF);
        run_op(4'b0100, 2, 1'b1, 1'b0, "ovf_neg");
        set_op(3, -32'sd7, -32'sd7);
        run_op(4'b1000, 3, 1'b0, 1'b1, "equal");

        // Fairness: all requesters held valid, one response every 3 cycles.
        set_op(0, 32'hFFFF_FFFF, 32'd0);   fair_lt[0] = 1'b1;
        set_op(1, 32'd0, 32'hFFFF_FFFF);   fair_lt[1] = 1'b0;
        set_op(2, 32'd100, -32'sd100);     fair_lt[2] = 1'b0;
        set_op(3, -32'sd100, 32'd100);     fair_lt[3] = 1'b1;
        fair_ids = '{0, 1, 2, 3, 0};
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while (!rsp_valid && w < 10) begin
                tick;
                w++;
            end
            check("fair_seen", rsp_valid, 1);
            check("fair_id", rsp_id, fair_ids[k]);
            check("fair_lt", rsp_lt, fair_lt[fair_ids[k]]);
            if (k > 0) check("fair_gap", cyc - last, 3);
            last = cyc;
            tick;
        end
        req_valid = '0;

        // Backpressure: rr is now 1, so requester 2 wins; late requests wait.
        rsp_ready = 1'b0;
        set_op(2, -32'sd6, -32'sd5);
        req_valid = 4'b0100;
        #1;
        check("bp_grant", req_ready, 4'b0100);
        tick;
        req_valid = 4'b1111;
        tick;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", rsp_valid, 1);
            check("bp_id", rsp_id, 2);
            check("bp_lt", rsp_lt, 1);
            check("bp_ready", req_ready, 0);
            tick;
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_valid", rsp_valid, 1);
        tick;
        check("bp_idle_valid", rsp_valid, 0);
        check("bp_hold_id", rsp_id, 2);
        check("bp_hold_lt", rsp_lt, 1);
        check("bp_next_grant", req_ready, 4'b1000);
        req_valid = '0;
        #1;

        // Reset during CALC aborts the op and returns rr to 0.
        set_op(1, 32'd1, 32'd2);
        req_valid = 4'b0010;
        #1;
        check("rmid_grant", req_ready, 4'b0010);
        tick;
        req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        check("rmid_ready", req_ready, 0);
        check("rmid_valid", rsp_valid, 0);
        check("rmid_id", rsp_id, 0);
        check("rmid_lt", rsp_lt, 0);
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("rmid_no_rsp", rsp_valid, 0);
        end
        set_op(2, 32'h8000_0000, 32'd0);
        set_op(3, 32'd0, 32'd0);
        run_op(4'b1100, 2, 1'b1, 1'b0, "rmid_next");

        // Random traffic against an in-order scoreboard.
        for (int i = 0; i < NREQ; i++) new_operands(i);
        issued = 0;
        done   = 0;
        guard  = 0;
        while ((issued < NOPS || sb.size() > 0) && guard < 80000) begin
            guard++;
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (issued >= NOPS) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) == 0);
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                    new_operands(i);
                end
            end
            #1;
            check("rnd_ready_ok", $onehot0(req_ready) && ((req_ready & ~req_valid) == '0), 1);
            acc = req_ready & req_valid;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    e.id = i;
                    e.lt = ($signed(ra[i]) < $signed(rb[i]));
                    e.eq = (ra[i] == rb[i]);
                    sb.push_back(e);
                    issued++;
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("rnd_spurious", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("rnd_id", rsp_id, e.id);
                    check("rnd_lt", rsp_lt, e.lt);
`ifdef CMP_ARBITER_EQ_EN
                    check("rnd_eq", rsp_eq, e.eq);
`endif
                    done++;
                end
            end
            tick;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    req_valid[i] = 1'b0;
                    new_operands(i);
                end
            end
        end
        check("rnd_drained", sb.size(), 0);
        check("rnd_issued", issued, NOPS);
        check("rnd_done", done, issued);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
